// File: rtl/executa_move_asteroides_pkg.sv
// rtl/executa_move_asteroides_pkg.sv - shared state codes, opcodes and step vectors for the asteroid mover
package executa_move_asteroides_pkg;

   localparam int N_ASTEROIDES_PADRAO = 16;
   localparam int COORD_W_PADRAO      = 4;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      LE      = 3'd1,
      ESPERA  = 3'd2,
      CALCULA = 3'd3,
      ESCREVE = 3'd4,
      FIM     = 3'd5
   } estado_t;

   typedef enum logic [2:0] {
      OP_N  = 3'd0,
      OP_NE = 3'd1,
      OP_L  = 3'd2,
      OP_SE = 3'd3,
      OP_S  = 3'd4,
      OP_SO = 3'd5,
      OP_O  = 3'd6,
      OP_NO = 3'd7
   } opcode_t;

   // Step per axis: 00 = stay, 01 = +1, 11 = -1 (y grows downward)
   localparam logic [1:0] PASSO_ZERO = 2'b00;
   localparam logic [1:0] PASSO_POS  = 2'b01;
   localparam logic [1:0] PASSO_NEG  = 2'b11;

   typedef struct packed {
      logic [1:0] dx;
      logic [1:0] dy;
   } passo_t;

   function automatic passo_t passo_de(input logic [2:0] opcode);
      passo_t p;
      case (opcode_t'(opcode))
         OP_N:    p = '{dx: PASSO_ZERO, dy: PASSO_NEG};
         OP_NE:   p = '{dx: PASSO_POS,  dy: PASSO_NEG};
         OP_L:    p = '{dx: PASSO_POS,  dy: PASSO_ZERO};
         OP_SE:   p = '{dx: PASSO_POS,  dy: PASSO_POS};
         OP_S:    p = '{dx: PASSO_ZERO, dy: PASSO_POS};
         OP_SO:   p = '{dx: PASSO_NEG,  dy: PASSO_POS};
         OP_O:    p = '{dx: PASSO_NEG,  dy: PASSO_ZERO};
         default: p = '{dx: PASSO_NEG,  dy: PASSO_NEG};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/executa_move_asteroides_calcula_passo_asteroide.sv
// rtl/executa_move_asteroides_calcula_passo_asteroide.sv - one-cell move of an object, dropping it at the field border
module calcula_passo_asteroide
   import executa_move_asteroides_pkg::*;
#(
   parameter int COORD_W = COORD_W_PADRAO
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [2:0]         opcode,
   input  logic               loaded,
   output logic [COORD_W-1:0] new_x,
   output logic [COORD_W-1:0] new_y,
   output logic               new_loaded
);

   localparam logic [COORD_W-1:0] MAXIMO = '1;
   localparam logic [COORD_W-1:0] UM     = COORD_W'(1);

   passo_t passo;
   logic   borda;

   assign passo = passo_de(opcode);

   always_comb begin
      borda = ((passo.dx == PASSO_NEG) && (x == '0))     ||
              ((passo.dx == PASSO_POS) && (x == MAXIMO)) ||
              ((passo.dy == PASSO_NEG) && (y == '0))     ||
              ((passo.dy == PASSO_POS) && (y == MAXIMO));
      new_x      = x;
      new_y      = y;
      new_loaded = loaded & ~borda;
      // Leaving the field keeps the old coordinates; only the loaded flag drops
      if (!borda) begin
         if (passo.dx == PASSO_POS)      new_x = x + UM;
         else if (passo.dx == PASSO_NEG) new_x = x - UM;
         if (passo.dy == PASSO_POS)      new_y = y + UM;
         else if (passo.dy == PASSO_NEG) new_y = y - UM;
      end
   end

endmodule

// File: rtl/executa_move_asteroides.sv
// rtl/executa_move_asteroides.sv - walks the asteroid table on start, moves each loaded entry, signals done
module executa_move_asteroides
   import executa_move_asteroides_pkg::*;
#(
   parameter int N_ASTEROIDES = N_ASTEROIDES_PADRAO,
   parameter int ADDR_W       = 4,
   parameter int COORD_W      = COORD_W_PADRAO
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               inicia_move_asteroides,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [COORD_W-1:0] mem_rd_x,
   input  logic [COORD_W-1:0] mem_rd_y,
   input  logic [2:0]         mem_rd_opcode,
   input  logic               mem_rd_loaded,
   output logic               mem_we,
   output logic [COORD_W-1:0] mem_wr_x,
   output logic [COORD_W-1:0] mem_wr_y,
   output logic               mem_wr_loaded,
   output logic               movimentacao_concluida_asteroides,
   output logic               ocupado,
   output logic [2:0]         db_estado_move_asteroides
);

   localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_ASTEROIDES - 1);

   estado_t            estado, proximo;
   logic [ADDR_W-1:0]  contador;
   logic               escrita_pendente;
   logic [COORD_W-1:0] novo_x, novo_y;
   logic               novo_loaded;

   calcula_passo_asteroide #(.COORD_W(COORD_W)) u_passo (
      .x          (mem_rd_x),
      .y          (mem_rd_y),
      .opcode     (mem_rd_opcode),
      .loaded     (mem_rd_loaded),
      .new_x      (novo_x),
      .new_y      (novo_y),
      .new_loaded (novo_loaded)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado <= OCIOSO;
      else        estado <= proximo;
   end

   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO:  if (inicia_move_asteroides) proximo = LE;
         LE:      proximo = ESPERA;
         ESPERA:  proximo = CALCULA;
         CALCULA: proximo = ESCREVE;
         ESCREVE: proximo = (contador == ULTIMO) ? FIM : LE;
         FIM:     if (!inicia_move_asteroides) proximo = OCIOSO;
         default: proximo = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contador <= '0;
      end else if (estado == OCIOSO) begin
         contador <= '0;
      end else if ((estado == ESCREVE) && (contador != ULTIMO)) begin
         contador <= contador + ADDR_W'(1);
      end
   end

   // The write strobe follows the entry's original loaded flag, so unloaded slots are never touched
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_wr_x         <= '0;
         mem_wr_y         <= '0;
         mem_wr_loaded    <= 1'b0;
         escrita_pendente <= 1'b0;
      end else if (estado == CALCULA) begin
         mem_wr_x         <= novo_x;
         mem_wr_y         <= novo_y;
         mem_wr_loaded    <= novo_loaded;
         escrita_pendente <= mem_rd_loaded;
      end
   end

   assign mem_addr                          = contador;
   assign mem_we                            = (estado == ESCREVE) && escrita_pendente;
   assign movimentacao_concluida_asteroides = (estado == FIM);
   assign ocupado                           = (estado != OCIOSO);
   assign db_estado_move_asteroides         = estado;

endmodule

// File: tb/tb_executa_move_asteroides.sv
// tb/tb_executa_move_asteroides.sv - directed bench for executa_move_asteroides with a table memory model
module tb_executa_move_asteroides;

   localparam int N = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       inicia = 1'b0;
   logic [3:0] mem_addr;
   logic [3:0] rd_x, rd_y;
   logic [2:0] rd_op;
   logic       rd_ld;
   logic       mem_we;
   logic [3:0] wr_x, wr_y;
   logic       wr_ld;
   logic       done, ocupado;
   logic [2:0] db;

   executa_move_asteroides #(.N_ASTEROIDES(16), .ADDR_W(4), .COORD_W(4)) dut (
      .clock                             (clock),
      .reset                             (reset),
      .inicia_move_asteroides            (inicia),
      .mem_addr                          (mem_addr),
      .mem_rd_x                          (rd_x),
      .mem_rd_y                          (rd_y),
      .mem_rd_opcode                     (rd_op),
      .mem_rd_loaded                     (rd_ld),
      .mem_we                            (mem_we),
      .mem_wr_x                          (wr_x),
      .mem_wr_y                          (wr_y),
      .mem_wr_loaded                     (wr_ld),
      .movimentacao_concluida_asteroides (done),
      .ocupado                           (ocupado),
      .db_estado_move_asteroides         (db)
   );

   always #5 clock = ~clock;

   logic [3:0] m_x[N], m_y[N], i_x[N], i_y[N];
   logic [2:0] m_op[N], i_op[N];
   logic       m_ld[N], i_ld[N];
   int         wr_cnt[N];
   int         conflitos;
   logic       carrega = 1'b0;

   always @(posedge clock) begin
      rd_x  <= m_x[mem_addr];
      rd_y  <= m_y[mem_addr];
      rd_op <= m_op[mem_addr];
      rd_ld <= m_ld[mem_addr];
      if (carrega) begin
         for (int i = 0; i < N; i++) begin
            m_x[i] <= i_x[i]; m_y[i] <= i_y[i]; m_op[i] <= i_op[i]; m_ld[i] <= i_ld[i];
            wr_cnt[i] <= 0;
         end
         conflitos <= 0;
      end else if (mem_we) begin
         m_x[mem_addr]    <= wr_x;
         m_y[mem_addr]    <= wr_y;
         m_ld[mem_addr]   <= wr_ld;
         wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
         if (done) conflitos <= conflitos + 1;
      end
   end

   typedef struct {
      int x, y, op, ld;
      int ex, ey, eld, ewr;
   } vec_t;

   vec_t vt[N];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
      end
   endtask

   task automatic carregar();
      carrega = 1'b1;
      @(posedge clock); #1;
      carrega = 1'b0;
   endtask

   task automatic carregar_tabela();
      for (int i = 0; i < N; i++) begin
         i_x[i] = 4'(vt[i].x); i_y[i] = 4'(vt[i].y); i_op[i] = 3'(vt[i].op); i_ld[i] = 1'(vt[i].ld);
      end
      carregar();
   endtask

   task automatic carregar_uniforme(input int ld2);
      for (int i = 0; i < N; i++) begin
         i_x[i] = 4'd8; i_y[i] = 4'd8; i_op[i] = 3'd2; i_ld[i] = (i == ld2) ? 1'b0 : 1'b1;
      end
      carregar();
   endtask

   task automatic esperar_done(output int lat);
      lat = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clock); #1;
         lat++;
         if (done) break;
      end
   endtask

   task automatic iniciar_walk(output int lat);
      inicia = 1'b1;
      @(posedge clock); #1;
      chk("start_state_le", int'(db), 1);
      chk("start_addr_0", int'(mem_addr), 0);
      esperar_done(lat);
   endtask

   task automatic soltar_e_conferir(input string nome);
      inicia = 1'b0;
      @(posedge clock); #1;
      chk({nome, "_done_fall"}, int'(done), 0);
      chk({nome, "_state_idle"}, int'(db), 0);
   endtask

   int lat, soma;

   initial begin
      vt[0]  = '{8, 8, 0, 1,   8, 7, 1, 1};
      vt[1]  = '{8, 8, 1, 1,   9, 7, 1, 1};
      vt[2]  = '{8, 8, 2, 0,   8, 8, 0, 0};
      vt[3]  = '{15, 4, 3, 1,  15, 4, 0, 1};
      vt[4]  = '{8, 8, 4, 1,   8, 9, 1, 1};
      vt[5]  = '{8, 8, 5, 1,   7, 9, 1, 1};
      vt[6]  = '{8, 8, 6, 1,   7, 8, 1, 1};
      vt[7]  = '{0, 0, 7, 1,   0, 0, 0, 1};
      vt[8]  = '{0, 5, 0, 1,   0, 4, 1, 1};
      vt[9]  = '{5, 0, 0, 1,   5, 0, 0, 1};
      vt[10] = '{15, 15, 4, 1, 15, 15, 0, 1};
      vt[11] = '{3, 15, 2, 1,  4, 15, 1, 1};
      vt[12] = '{0, 15, 6, 1,  0, 15, 0, 1};
      vt[13] = '{15, 0, 1, 1,  15, 0, 0, 1};
      vt[14] = '{1, 1, 7, 1,   0, 0, 1, 1};
      vt[15] = '{14, 14, 3, 1, 15, 15, 1, 1};

      repeat (2) @(posedge clock);
      #1;
      chk("rst_state", int'(db), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ocupado", int'(ocupado), 0);
      chk("rst_we", int'(mem_we), 0);
      chk("rst_addr", int'(mem_addr), 0);
      chk("rst_wr_x", int'(wr_x), 0);
      chk("rst_wr_y", int'(wr_y), 0);
      chk("rst_wr_ld", int'(wr_ld), 0);
      reset = 1'b1;
      @(posedge clock); #1;

      // Mixed directions, borders and one unloaded slot
      carregar_tabela();
      iniciar_walk(lat);
      chk("tab_latency", lat, 64);
      soltar_e_conferir("tab");
      for (int i = 0; i < N; i++) begin
         chk($sformatf("tab_x[%0d]", i), int'(m_x[i]), vt[i].ex);
         chk($sformatf("tab_y[%0d]", i), int'(m_y[i]), vt[i].ey);
         chk($sformatf("tab_ld[%0d]", i), int'(m_ld[i]), vt[i].eld);
         chk($sformatf("tab_writes[%0d]", i), wr_cnt[i], vt[i].ewr);
      end
      chk("tab_done_with_we", conflitos, 0);

      // All loaded, moving east; done held while start stays high
      carregar_uniforme(-1);
      iniciar_walk(lat);
      chk("east_latency", lat, 64);
      repeat (3) @(posedge clock);
      #1;
      chk("east_done_held", int'(done), 1);
      chk("east_state_fim", int'(db), 5);
      soltar_e_conferir("east");
      for (int i = 0; i < N; i++) begin
         chk($sformatf("east_entry[%0d]", i),
             int'({m_x[i], m_y[i], 3'b000, m_ld[i]}), int'({4'd9, 4'd8, 4'd1}));
         chk($sformatf("east_writes[%0d]", i), wr_cnt[i], 1);
      end

      // Entry 2 unloaded: never written, latency unchanged
      carregar_uniforme(2);
      iniciar_walk(lat);
      chk("skip_latency", lat, 64);
      soltar_e_conferir("skip");
      chk("skip_writes_2", wr_cnt[2], 0);
      chk("skip_entry_2_x", int'(m_x[2]), 8);
      chk("skip_writes_3", wr_cnt[3], 1);

      // Single-cycle start pulse
      carregar_uniforme(-1);
      inicia = 1'b1;
      @(posedge clock); #1;
      inicia = 1'b0;
      esperar_done(lat);
      chk("pulse_latency", lat, 64);
      @(posedge clock); #1;
      chk("pulse_done_one_cycle", int'(done), 0);
      chk("pulse_state_idle", int'(db), 0);
      repeat (40) @(posedge clock);
      #1;
      chk("pulse_no_restart", int'(ocupado), 0);
      soma = 0;
      for (int i = 0; i < N; i++) soma += wr_cnt[i];
      chk("pulse_total_writes", soma, 16);

      // Asynchronous reset while reading entry 5
      carregar_tabela();
      inicia = 1'b1;
      lat = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clock); #1;
         lat++;
         if (db == 3'd1 && mem_addr == 4'd5) break;
      end
      chk("midrst_reached_le5", lat, 21);
      inicia = 1'b0;
      reset = 1'b0;
      #1;
      chk("midrst_state", int'(db), 0);
      chk("midrst_we", int'(mem_we), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_ocupado", int'(ocupado), 0);
      chk("midrst_addr", int'(mem_addr), 0);
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("midrst_entry4_y", int'(m_y[4]), 9);
      chk("midrst_entry5_x", int'(m_x[5]), 8);
      chk("midrst_writes5", wr_cnt[5], 0);
      chk("midrst_state_after", int'(db), 0);
      iniciar_walk(lat);
      chk("midrst_rewalk_latency", lat, 64);
      soltar_e_conferir("midrst");
      chk("midrst_entry5_moved", int'(m_x[5]), 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
